decoder2_4_strobe_seq: RTL and testbench

DECODER2_4_STROBE_SEQ -- requirements
Module: decoder2_4_strobe_seq

---
 rtl/decoder2_4_strobe_seq.sv | 163 ++++++++++++++++
 tb/tb_decoder2_4_strobe_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/decoder2_4_strobe_seq.sv
// 2-to-4 decoder with a timed strobe sequencer.
// An accepted 2-bit code drives one of Y3..Y0 for HOLD cycles.
// A forced idle gap of GAP cycles follows each strobe.
// done pulses on the last strobe cycle. Dropping en mid-strobe aborts it.
module decoder2_4_strobe_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid,
    input  logic A1,
    input  logic A0,
    output logic ready,
    output logic Y3,
    output logic Y2,
    output logic Y1,
    output logic Y0,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam bit         HAS_GAP   = (GAP > 0);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);
    localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    // One-hot decode of the 2-bit code; code 0 maps to Y0.
    function automatic logic [3:0] decode_onehot(input logic [1:0] code);
        logic [3:0] oh;
        case (code)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] code_q,  code_d;
    logic [3:0] y_q,     y_d;
    logic       done_q,  done_d;
    logic       ready_s;
    logic       accept_s;

    // Handshake terms: ready and busy are both masked while reset is asserted.
    always_comb begin
        ready_s  = rst_n & en & (state_q == ST_IDLE);
        accept_s = ready_s & valid;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            code_q  <= 2'd0;
            y_q     <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; an abort (en low in DRIVE) wins over strobe completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = HAS_GAP ? ST_GAP : ST_IDLE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and counter logic; values settle into registers one cycle ahead of their use.
    always_comb begin
        cnt_d  = cnt_q;
        code_d = code_q;
        y_d    = 4'b0000;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    code_d = {A1, A0};
                    cnt_d  = HOLD_LOAD;
                    y_d    = decode_onehot({A1, A0});
                    done_d = (HOLD_LOAD == 4'd0);
                end else begin
                    cnt_d  = 4'd0;
                end
            end
            ST_DRIVE: begin
                if (!en) begin
                    cnt_d = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    cnt_d = GAP_LOAD;
                end else begin
                    // Still mid-strobe: keep driving and flag done one cycle early
                    // so the registered pulse lines up with the final strobe cycle.
                    cnt_d  = cnt_q - 4'd1;
                    y_d    = decode_onehot(code_q);
                    done_d = (cnt_q == 4'd1);
                end
            end
            ST_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = 4'd0;
                end
            end
            default: begin
                cnt_d = 4'd0;
            end
        endcase
    end

    // Port mapping of registered and handshake signals.
    always_comb begin
        ready = ready_s;
        busy  = rst_n & (state_q != ST_IDLE);
        done  = done_q;
        Y3    = y_q[3];
        Y2    = y_q[2];
        Y1    = y_q[1];
        Y0    = y_q[0];
    end

endmodule

// File: tb/tb_decoder2_4_strobe_seq.sv
// Directed bench: dut_a uses HOLD=4/GAP=1, dut_b uses HOLD=1/GAP=0.
// Observed vector per cycle is {busy, ready, done, Y3, Y2, Y1, Y0}.
module tb_decoder2_4_strobe_seq;

    logic clk = 1'b0;
    logic rst_n, en, valid, A1, A0;
    logic rdy_a, y3_a, y2_a, y1_a, y0_a, busy_a, done_a;
    logic rdy_b, y3_b, y2_b, y1_b, y0_b, busy_b, done_b;
    int   checks_cnt   = 0;
    int   failures_cnt = 0;

    always #5 clk = ~clk;

    decoder2_4_strobe_seq #(.HOLD(4), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .valid(valid), .A1(A1), .A0(A0),
        .ready(rdy_a), .Y3(y3_a), .Y2(y2_a), .Y1(y1_a), .Y0(y0_a),
        .busy(busy_a), .done(done_a)
    );

    decoder2_4_strobe_seq #(.HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .valid(valid), .A1(A1), .A0(A0),
        .ready(rdy_b), .Y3(y3_b), .Y2(y2_b), .Y1(y1_b), .Y0(y0_b),
        .busy(busy_b), .done(done_b)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got %b expected %b (busy,ready,done,Y3..Y0)", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input bit sel_b, input bit r, input bit e,
                       input bit v, input logic [1:0] c, input logic [6:0] exp);
        logic [6:0] obs;
        rst_n = r; en = e; valid = v; {A1, A0} = c;
        #3;
        if (sel_b) obs = {busy_b, rdy_b, done_b, y3_b, y2_b, y1_b, y0_b};
        else       obs = {busy_a, rdy_a, done_a, y3_a, y2_a, y1_a, y0_a};
        check_eq(tag, obs, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] oh;
        rst_n = 1'b0; en = 1'b1; valid = 1'b1; {A1, A0} = 2'd3;
        @(posedge clk); #1;

        // Reset state: outputs and ready held low while rst_n is low.
        cyc("rst_hold_a", 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 7'b0000000);
        cyc("rst_hold_b", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 7'b0000000);
        cyc("post_rst_en0", 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 7'b0000000);

        // Single strobe code 10.
        cyc("s1_accept", 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 7'b0100000);
        cyc("s1_t1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("s1_t2", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("s1_t3", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("s1_t4_done", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1010100);
        cyc("s1_t5_gap", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000000);
        cyc("s1_t6_ready", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b0100000);

        // Back-to-back codes with valid held high; the next code sits on A during the strobe.
        for (int c = 0; c < 4; c++) begin
            oh = 4'b0001 << c;
            cyc("b2b_accept", 1'b0, 1'b1, 1'b1, 1'b1, 2'(c), 7'b0100000);
            for (int k = 1; k <= 3; k++)
                cyc("b2b_drive", 1'b0, 1'b1, 1'b1, 1'b1, 2'(c + 1), {3'b100, oh});
            cyc("b2b_done", 1'b0, 1'b1, 1'b1, 1'b1, 2'(c + 1), {3'b101, oh});
            cyc("b2b_gap", 1'b0, 1'b1, 1'b1, 1'b1, 2'(c + 1), 7'b1000000);
        end

        // Abort: en low at second DRIVE cycle of code 11.
        cyc("ab_accept", 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 7'b0100000);
        cyc("ab_t1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 7'b1001000);
        cyc("ab_t2_en0", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 7'b1001000);
        cyc("ab_t3_idle", 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 7'b0000000);
        cyc("ab_t4_idle", 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 7'b0000000);
        cyc("ab_en_back", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 7'b0100000);

        // Abort on the cycle that would otherwise raise done: no done pulse.
        cyc("abd_accept", 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 7'b0100000);
        cyc("abd_t1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("abd_t2", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("abd_t3_en0", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 7'b1000100);
        cyc("abd_t4_nodone", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 7'b0000000);

        // Reset mid-DRIVE, then immediate re-accept of code 10.
        cyc("rd_accept", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 7'b0100000);
        cyc("rd_t1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'b1000001);
        cyc("rd_rst", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 7'b0000001);
        cyc("rd_reaccept", 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 7'b0100000);
        cyc("rd_t1b", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("rd_t2b", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("rd_t3b", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000100);
        cyc("rd_t4b_done", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1010100);
        cyc("rd_gap", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'b1000000);

        // New code pulsed mid-DRIVE is ignored; code 01 completes.
        cyc("ig_accept", 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 7'b0100000);
        cyc("ig_t1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 7'b1000010);
        cyc("ig_t2_pulse", 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 7'b1000010);
        cyc("ig_t3", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'b1000010);
        cyc("ig_t4_done", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'b1010010);
        cyc("ig_gap", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'b1000000);
        cyc("ig_idle", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'b0100000);

        // HOLD=1, GAP=0 instance: fresh reset, then accepts every 2 cycles.
        cyc("b_rst", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'b0000000);
        for (int c = 0; c < 4; c++) begin
            oh = 4'b0001 << c;
            cyc("h1_accept", 1'b1, 1'b1, 1'b1, 1'b1, 2'(c), 7'b0100000);
            cyc("h1_strobe", 1'b1, 1'b1, 1'b1, 1'b1, 2'(c + 1), {3'b101, oh});
        end
        cyc("h1_idle", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 7'b0100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
